// File: rtl/param_updown_counter.sv
// Parametrised synchronous up/down counter with parallel load, synchronous clear,
// wrap or saturate at the boundaries, a registered terminal-count pulse and a sticky overflow flag.
module param_updown_counter #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
  parameter bit               SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             t,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             at_max, at_zero;

  assign at_max  = (q_q == MAX_COUNT);
  assign at_zero = (q_q == '0);

  always_comb begin
    q_d   = q_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (clear) begin
      q_d   = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      q_d = (load_val > MAX_COUNT) ? MAX_COUNT : load_val;
    end else if (t) begin
      if (up) begin
        if (at_max) begin
          // Boundary: wrap to 0 or hold; the step past MAX_COUNT is never computed.
          q_d   = SATURATE ? MAX_COUNT : '0;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          q_d   = SATURATE ? '0 : MAX_COUNT;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q   <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign Q     = q_q;
  assign Q_bar = ~q_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench: three counter configurations share one stimulus bus;
// each scenario task checks the instance it targets.
`timescale 1ns/1ps
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       t = 1'b0, up = 1'b1, load = 1'b0, clear = 1'b0;
  logic [3:0] load_val = '0;

  logic [3:0] qa, qba, qb, qbb, qc, qbc;
  logic       tca, ovfa, tcb, ovfb, tcc, ovfc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // a: 4-bit full range wrap; b: modulus 10 wrap; c: modulus 10 saturate
  param_updown_counter #(.WIDTH(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .t(t), .up(up), .load(load), .load_val(load_val),
    .clear(clear), .Q(qa), .Q_bar(qba), .tc(tca), .ovf(ovfa));
  param_updown_counter #(.WIDTH(4), .MAX_COUNT(4'd9), .SATURATE(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .t(t), .up(up), .load(load), .load_val(load_val),
    .clear(clear), .Q(qb), .Q_bar(qbb), .tc(tcb), .ovf(ovfb));
  param_updown_counter #(.WIDTH(4), .MAX_COUNT(4'd9), .SATURATE(1'b1)) dut_c (
    .clk(clk), .reset_n(reset_n), .t(t), .up(up), .load(load), .load_val(load_val),
    .clear(clear), .Q(qc), .Q_bar(qbc), .tc(tcc), .ovf(ovfc));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    t = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'd7; clear = 1'b0;
    step();
    step();
    checks++;
    if (qa !== 4'd0 || qba !== 4'hF || tca !== 1'b0 || ovfa !== 1'b0) begin
      failures++;
      $display("FAIL reset_a: Q=%0d Q_bar=%0d tc=%b ovf=%b want 0 15 0 0", qa, qba, tca, ovfa);
    end
    checks++;
    if (qb !== 4'd0 || tcb !== 1'b0 || ovfb !== 1'b0) begin
      failures++;
      $display("FAIL reset_b: Q=%0d tc=%b ovf=%b want 0 0 0", qb, tcb, ovfb);
    end
    $display("reset held: Q=%0d Q_bar=%0d", qa, qba);
    load = 1'b0;
  endtask

  task automatic test_free_run();
    logic [3:0] eq;
    t = 1'b1; up = 1'b1;
    reset_n = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step();
      eq = 4'(i % 16);
      checks++;
      if (qa !== eq || qba !== ~eq || tca !== (i == 16) || ovfa !== (i >= 16)) begin
        failures++;
        $display("FAIL free_run[%0d]: Q=%0d Q_bar=%0d tc=%b ovf=%b want %0d %0d %b %b",
                 i, qa, qba, tca, ovfa, eq, 4'(~eq), (i == 16), (i >= 16));
      end
      $display("free_run step %0d: Q=%0d tc=%b ovf=%b", i, qa, tca, ovfa);
    end
  endtask

  task automatic test_modulus_down();
    int exp_q[11] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 9};
    int exp_tc[11] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    up = 1'b0; t = 1'b1;
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step();
      checks++;
      if (qb !== 4'(exp_q[i]) || tcb !== 1'(exp_tc[i]) || ovfb !== 1'b1) begin
        failures++;
        $display("FAIL mod_down[%0d]: Q=%0d tc=%b ovf=%b want %0d %0d 1",
                 i, qb, tcb, ovfb, exp_q[i], exp_tc[i]);
      end
      $display("mod_down step %0d: Q=%0d tc=%b", i, qb, tcb);
    end
  endtask

  task automatic test_saturate();
    int exp_q[5] = '{8, 9, 9, 9, 8};
    int exp_tc[5] = '{0, 0, 1, 1, 0};
    int exp_ovf[5] = '{0, 0, 1, 1, 1};
    clear = 1'b1; t = 1'b0;
    step();
    clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load = (i == 0); load_val = 4'd8;
      t = (i != 0);
      up = (i != 4);
      step();
      checks++;
      if (qc !== 4'(exp_q[i]) || tcc !== 1'(exp_tc[i]) || ovfc !== 1'(exp_ovf[i])) begin
        failures++;
        $display("FAIL saturate[%0d]: Q=%0d tc=%b ovf=%b want %0d %0d %0d",
                 i, qc, tcc, ovfc, exp_q[i], exp_tc[i], exp_ovf[i]);
      end
      $display("saturate step %0d: Q=%0d tc=%b ovf=%b", i, qc, tcc, ovfc);
    end
    load = 1'b0;
  endtask

  task automatic test_load_clear();
    // columns: clear load t up load_val | Q tc ovf
    int vec[6][8] = '{
      '{1, 0, 0, 1, 0,  0, 0, 0},
      '{0, 1, 0, 1, 12, 9, 0, 0},
      '{0, 0, 1, 1, 0,  0, 1, 1},
      '{0, 1, 0, 1, 3,  3, 0, 1},
      '{1, 1, 0, 1, 5,  0, 0, 0},
      '{0, 1, 1, 1, 4,  4, 0, 0}
    };
    for (int i = 0; i < 6; i++) begin
      clear = 1'(vec[i][0]); load = 1'(vec[i][1]); t = 1'(vec[i][2]);
      up = 1'(vec[i][3]); load_val = 4'(vec[i][4]);
      step();
      checks++;
      if (qb !== 4'(vec[i][5]) || tcb !== 1'(vec[i][6]) || ovfb !== 1'(vec[i][7])) begin
        failures++;
        $display("FAIL load_clear[%0d]: Q=%0d tc=%b ovf=%b want %0d %0d %0d",
                 i, qb, tcb, ovfb, vec[i][5], vec[i][6], vec[i][7]);
      end
      $display("load_clear vec %0d: Q=%0d tc=%b ovf=%b", i, qb, tcb, ovfb);
    end
    clear = 1'b0; load = 1'b0;
  endtask

  task automatic test_async_reset();
    load = 1'b1; load_val = 4'd15; t = 1'b0; up = 1'b1;
    step();
    load = 1'b0; t = 1'b1;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (qa !== 4'd5 || ovfa !== 1'b1) begin
      failures++;
      $display("FAIL async_pre: Q=%0d ovf=%b want 5 1", qa, ovfa);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (qa !== 4'd0 || qba !== 4'hF || ovfa !== 1'b0 || tca !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: Q=%0d Q_bar=%0d tc=%b ovf=%b want 0 15 0 0", qa, qba, tca, ovfa);
    end
    $display("async reset between edges: Q=%0d Q_bar=%0d ovf=%b", qa, qba, ovfa);
    reset_n = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      step();
      checks++;
      if (qa !== 4'(i)) begin
        failures++;
        $display("FAIL async_resume[%0d]: Q=%0d want %0d", i, qa, i);
      end
      $display("resume step %0d: Q=%0d", i, qa);
    end
  endtask

  task automatic test_enable_gating();
    int en[7]  = '{1, 1, 0, 1, 0, 1, 0};
    int eq[7]  = '{0, 1, 1, 2, 2, 3, 3};
    int etc[7] = '{1, 0, 0, 0, 0, 0, 0};
    load = 1'b1; load_val = 4'd15; up = 1'b1; t = 1'b0;
    step();
    load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      t = 1'(en[i]);
      step();
      checks++;
      if (qa !== 4'(eq[i]) || tca !== 1'(etc[i]) || ovfa !== 1'b1) begin
        failures++;
        $display("FAIL gating[%0d]: Q=%0d tc=%b ovf=%b want %0d %0d 1",
                 i, qa, tca, ovfa, eq[i], etc[i]);
      end
      $display("gating step %0d t=%0d: Q=%0d tc=%b ovf=%b", i, en[i], qa, tca, ovfa);
    end
    t = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_modulus_down();
    test_saturate();
    test_load_clear();
    test_async_reset();
    test_enable_gating();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
